uart_rx_brg: RTL

//   UART receive path: free-running 16x oversampling baud tick generator plus an
//   8N1-style receiver FSM, in one block. Counterpart of the tx+brg block.

---
 rtl/uart_rx_brg.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_brg.sv
// UART receiver with built-in 16x oversampling baud tick generator.
// Deserialises an idle-high, LSB-first serial line into NB_DATA-bit words with a done pulse.
module uart_rx_brg #(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx,
    output logic [NB_DATA-1:0] dout,
    output logic               rx_done_tick,
    output logic               frame_err
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] S_MID    = SW'(7);
    localparam logic [SW-1:0] S_BIT    = SW'(15);
    localparam logic [SW-1:0] S_STOP   = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Free-running oversample tick; never realigned to the start edge.
    logic [CW-1:0] cnt_reg;
    logic          tick;

    assign tick = (cnt_reg == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Two-stage synchroniser, preset to the idle level so reset never looks like a start bit.
    logic rx_meta_reg;
    logic rx_s_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    state_t             state_reg, state_next;
    logic [SW-1:0]      s_reg, s_next;
    logic [NW-1:0]      n_reg, n_next;
    logic [NB_DATA-1:0] b_reg, b_next;
    logic [NB_DATA-1:0] dout_reg, dout_next;
    logic               done_reg, done_next;
    logic               ferr_reg, ferr_next;
    logic [NB_DATA-1:0] b_shifted;

    // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
    assign b_shifted[NB_DATA-1] = rx_s_reg;
    generate
        for (genvar gi = 0; gi < NB_DATA - 1; gi++) begin : g_shift
            assign b_shifted[gi] = b_reg[gi+1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;
        case (state_reg)
            IDLE: begin
                if (!rx_s_reg) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_reg == S_MID) begin
                        // Mid start bit: a line already back high was only a glitch.
                        if (!rx_s_reg) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_reg == S_BIT) begin
                        s_next = '0;
                        b_next = b_shifted;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_reg == S_STOP) begin
                        dout_next  = b_reg;
                        done_next  = 1'b1;
                        ferr_next  = ~rx_s_reg;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dout         = dout_reg;
    assign rx_done_tick = done_reg;
    assign frame_err    = ferr_reg;

endmodule
